seven_seg_decoder: RTL and testbench

//  Inverse of the segment encoder: samples an 8-bit segment bus {dp,g,f,e,d,c,b,a} from
//  the display path or external pins, and waits until the pattern is stable.

---
 rtl/seven_seg_pkg.sv | 32 +++
 rtl/seven_seg_lut.sv | 39 +++
 rtl/seven_seg_decoder.sv | 129 ++++++++++++
 tb/tb_seven_seg_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Segment patterns shared by the seven-segment encoder and decoder, so both use one table.
// Bit order is {g,f,e,d,c,b,a}; bit 0 is the top segment.
package seven_seg_pkg;

  localparam int DP_BIT = 7;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  // 6 and B share a glyph; the decoder resolves it to B and flags it.
  localparam logic [6:0] SEG_AMBIG = 7'b1111100;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HELD = 1'b1
  } dec_state_t;

endpackage

// File: rtl/seven_seg_lut.sv
// Combinational reverse lookup: 7-bit segment pattern -> {known, ambig, nibble}.
// Unknown patterns (including blank) return known=0 and nibble 0.
module seven_seg_lut
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_known,
  output logic       o_ambig,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_known  = 1'b1;
    o_ambig  = 1'b0;
    o_nibble = 4'h0;
    case (i_seg)
      SEG_0:     o_nibble = 4'h0;
      SEG_1:     o_nibble = 4'h1;
      SEG_2:     o_nibble = 4'h2;
      SEG_3:     o_nibble = 4'h3;
      SEG_4:     o_nibble = 4'h4;
      SEG_5:     o_nibble = 4'h5;
      SEG_AMBIG: begin
        o_nibble = 4'hB;
        o_ambig  = 1'b1;
      end
      SEG_7:     o_nibble = 4'h7;
      SEG_8:     o_nibble = 4'h8;
      SEG_9:     o_nibble = 4'h9;
      SEG_A:     o_nibble = 4'hA;
      SEG_C:     o_nibble = 4'hC;
      SEG_D:     o_nibble = 4'hD;
      SEG_E:     o_nibble = 4'hE;
      SEG_F:     o_nibble = 4'hF;
      default:   o_known  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_decoder.sv
// Debounces an 8-bit segment bus, decodes each newly stable pattern to {dp, nibble} and
// emits it on a registered valid/ready port; events arriving while the port is stalled are dropped.
module seven_seg_decoder
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic       seg_en_in,
  input  logic       clear_in,
  output logic [4:0] out_value,
  output logic       out_invalid,
  output logic       out_ambig,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow_o,
  output logic [7:0] err_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES);

  logic [7:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_last;
  dec_state_t    r_state;

  logic          w_same;
  logic          w_change;
  logic [7:0]    w_cand_nxt;
  logic [CW-1:0] w_cnt_nxt;
  dec_state_t    w_state_nxt;
  logic          w_accept;
  logic          w_emit;
  logic          w_known;
  logic          w_ambig;
  logic [3:0]    w_nibble;

  assign w_same     = (seg_in == r_cand);
  assign w_change   = seg_en_in && !w_same;
  assign w_cand_nxt = w_change ? seg_in : r_cand;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (seg_en_in) begin
      if (!w_same)
        w_cnt_nxt = CW'(1);
      else if (r_cnt != C_MAX)
        w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  // Threshold is judged on the post-edge count so the sample taken this edge counts.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_WAIT: w_accept = seg_en_in && (w_cnt_nxt == C_MAX) && (w_cand_nxt != r_last);
      ST_HELD: begin
        if (w_change) begin
          w_state_nxt = ST_WAIT;
          w_accept    = (w_cnt_nxt == C_MAX) && (w_cand_nxt != r_last);
        end
      end
      default: w_state_nxt = ST_WAIT;
    endcase
    if (w_accept)
      w_state_nxt = ST_HELD;
  end

  assign w_emit = w_accept && (w_cand_nxt[6:0] != SEG_BLANK);

  seven_seg_lut u_lut (
    .i_seg    (w_cand_nxt[6:0]),
    .o_known  (w_known),
    .o_ambig  (w_ambig),
    .o_nibble (w_nibble)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cand  <= 8'h00;
      r_cnt   <= '0;
      r_last  <= {1'b0, SEG_BLANK};
      r_state <= ST_WAIT;
    end else begin
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      if (w_accept)
        r_last <= w_cand_nxt;
    end
  end

  // A new event may load on the same edge the previous one is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_value   <= 5'h00;
      out_invalid <= 1'b0;
      out_ambig   <= 1'b0;
      out_valid   <= 1'b0;
    end else if (w_emit && (!out_valid || out_ready)) begin
      out_value   <= {w_cand_nxt[DP_BIT], w_known ? w_nibble : 4'h0};
      out_invalid <= !w_known;
      out_ambig   <= w_ambig;
      out_valid   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
      err_count  <= 8'h00;
    end else if (clear_in) begin
      overflow_o <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      if (w_emit && out_valid && !out_ready)
        overflow_o <= 1'b1;
      if (w_emit && !w_known && (err_count != 8'hFF))
        err_count <= err_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed self-checking bench for seven_seg_decoder (STABLE_CYCLES=3).
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
module tb_seven_seg_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] seg_in;
  logic       seg_en_in;
  logic       clear_in;
  logic [4:0] out_value;
  logic       out_invalid;
  logic       out_ambig;
  logic       out_valid;
  logic       out_ready;
  logic       overflow_o;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  seven_seg_decoder #(.STABLE_CYCLES(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .seg_en_in   (seg_en_in),
    .clear_in    (clear_in),
    .out_value   (out_value),
    .out_invalid (out_invalid),
    .out_ambig   (out_ambig),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow_o  (overflow_o),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    seg_in    = 8'h00;
    seg_en_in = 1'b1;
    clear_in  = 1'b0;
    out_ready = 1'b1;
    tick(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_value", 32'(out_value), 32'd0);
    chk("rst_flags", 32'({out_invalid, out_ambig, overflow_o}), 32'd0);
    chk("rst_err",   32'(err_count), 32'd0);
    rst_n = 1'b1;

    // 1: digit 0, valid appears on the third edge, single event
    seg_in = 8'h3F;
    tick(2);
    chk("t1_early", 32'(out_valid), 32'd0);
    tick(1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_value", 32'(out_value), 32'h00);
    chk("t1_flags", 32'({out_invalid, out_ambig}), 32'd0);
    tick(1);
    chk("t1_taken", 32'(out_valid), 32'd0);
    tick(5);
    chk("t1_norepeat", 32'(out_valid), 32'd0);

    // 2: ambiguous 6/B pattern, then 9 with dp
    seg_in = 8'h7C;
    tick(3);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_value", 32'(out_value), 32'h0B);
    chk("t2_ambig", 32'(out_ambig), 32'd1);
    seg_in = 8'hE7;
    tick(3);
    chk("t2_dp_valid", 32'(out_valid), 32'd1);
    chk("t2_dp_value", 32'(out_value), 32'h19);
    chk("t2_dp_ambig", 32'(out_ambig), 32'd0);
    tick(1);

    // 3: unstable '1' ignored, then '2'
    seg_in = 8'h06;
    tick(2);
    seg_in = 8'h5B;
    tick(2);
    chk("t3_none", 32'(out_valid), 32'd0);
    tick(1);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_value", 32'(out_value), 32'h02);
    tick(1);

    // 4: stalled consumer, second event dropped
    out_ready = 1'b0;
    seg_in = 8'h4F;
    tick(3);
    chk("t4_first", 32'(out_value), 32'h03);
    seg_in = 8'h66;
    tick(3);
    chk("t4_held_value", 32'(out_value), 32'h03);
    chk("t4_held_valid", 32'(out_valid), 32'd1);
    chk("t4_overflow", 32'(overflow_o), 32'd1);
    clear_in = 1'b1;
    tick(1);
    clear_in = 1'b0;
    chk("t4_clear", 32'(overflow_o), 32'd0);
    out_ready = 1'b1;
    tick(1);
    chk("t4_drain", 32'(out_valid), 32'd0);

    // 5: invalid pattern, then saturation of the error counter
    seg_in = 8'h49;
    tick(3);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_invalid", 32'(out_invalid), 32'd1);
    chk("t5_value", 32'(out_value), 32'h00);
    chk("t5_err", 32'(err_count), 32'd1);
    tick(1);
    for (int i = 0; i < 260; i++) begin
      seg_in = 8'h00;
      tick(3);
      seg_in = 8'h49;
      tick(3);
      if (i == 98)
        chk("t5_err_mid", 32'(err_count), 32'd100);
    end
    chk("t5_err_sat", 32'(err_count), 32'd255);
    chk("t5_no_ovf", 32'(overflow_o), 32'd0);
    clear_in = 1'b1;
    tick(1);
    clear_in = 1'b0;
    chk("t5_err_clr", 32'(err_count), 32'd0);

    // 6: blank between repeats re-arms, enable gap, reset mid-event
    seg_in = 8'h3F;
    tick(3);
    chk("t6_first", 32'({out_valid, out_value}), 32'h20);
    seg_in = 8'h00;
    tick(3);
    chk("t6_blank", 32'(out_valid), 32'd0);
    seg_in = 8'h3F;
    tick(3);
    chk("t6_second", 32'({out_valid, out_value}), 32'h20);
    tick(1);
    seg_in = 8'h5B;
    tick(1);
    seg_en_in = 1'b0;
    tick(2);
    seg_en_in = 1'b1;
    tick(1);
    chk("t6_gap_early", 32'(out_valid), 32'd0);
    tick(1);
    chk("t6_gap_valid", 32'({out_valid, out_value}), 32'h22);
    out_ready = 1'b0;
    tick(1);
    chk("t6_stall", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("t6_rst", 32'({out_valid, out_value, out_invalid, out_ambig, overflow_o, err_count}), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(2);
    chk("t6_restab_early", 32'(out_valid), 32'd0);
    tick(1);
    chk("t6_restab", 32'({out_valid, out_value}), 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
